rr_bus_arbiter: RTL and testbench

//   N-master bus arbiter for the serial system bus; successor of the 2-master arbiter.

---
 rtl/rr_bus_arbiter_if.sv | 15 +
 rtl/rr_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_if.sv
// Bus-side signals of the round-robin arbiter: requests in, grant/select/status out.
// The master modport is taken by the arbiter, the slave modport by the requesters.
interface rr_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MSEL_WIDTH  = 2
);
  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [MSEL_WIDTH-1:0]  msel;
  logic                   bbusy;
  logic                   timeout;

  modport master (input breq, output bgrant, output msel, output bbusy, output timeout);
  modport slave  (output breq, input bgrant, input msel, input bbusy, input timeout);
endinterface

// File: rtl/rr_bus_arbiter.sv
// N-master round-robin bus arbiter, no preemption, one idle turnaround cycle between owners.
// Optional grant-length limit is built when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MSEL_WIDTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              clk,
  input logic              rstn,
  rr_bus_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || MSEL_WIDTH < IDX_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rr_bus_arbiter: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MSEL_WIDTH-1:0]  msel_q, msel_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  int unsigned            cand;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Rotating priority: first requester after the last owner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(last_q) + k) % NUM_MASTERS;
      if (!pick_valid && bus.breq[IDX_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    msel_d    = msel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    owner_d   = owner_q;
    last_d    = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE, RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (pick_valid) begin
          state_d           = GRANT;
          grant_d[pick_idx] = 1'b1;
          msel_d            = MSEL_WIDTH'(pick_idx);
          owner_d           = pick_idx;
          busy_d            = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d             = CNT_W'(1);
`endif
        end
      end
      GRANT: begin
        if (!bus.breq[owner_q]) begin
          state_d = RELEASE;
          grant_d = '0;
          busy_d  = 1'b0;
          last_d  = owner_q;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // Owner overstayed: force release and hand priority to the next master.
          state_d   = RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          last_d    = owner_q;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      msel_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      msel_q    <= msel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.bgrant  = grant_q;
  assign bus.msel    = msel_q;
  assign bus.bbusy   = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios then random requests,
// all compared cycle by cycle against a behavioural owner/rotation model.
module tb_rr_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MW = 2;
  localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  rr_bus_arbiter_if #(.NUM_MASTERS(N), .MSEL_WIDTH(MW)) bus ();

  rr_bus_arbiter #(.NUM_MASTERS(N), .MSEL_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: who owns the bus (-1 = nobody), who owned it last, how long it has held it.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_msel  = 0;
  int m_cnt   = 0;
  bit m_tout  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_msel  = 0;
    m_cnt   = 0;
    m_tout  = 1'b0;
  endtask

  // One clock edge of the arbitration rules. A release edge never grants.
  task automatic model_edge(input logic [3:0] req);
    m_tout = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (TMO_EN && m_cnt == int'(TO)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_tout  = 1'b1;
      end else begin
        m_cnt++;
      end
    end else if (req != 4'b0000) begin
      for (int k = 1; k <= int'(N); k++) begin
        int c;
        c = (m_last + k) % int'(N);
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      m_msel = m_owner;
      m_cnt  = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bgrant"},  32'(bus.bgrant),  32'(exp_grant()));
    check({tag, ".msel"},    32'(bus.msel),    32'(m_msel));
    check({tag, ".bbusy"},   32'(bus.bbusy),   32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(m_tout));
    check({tag, ".onehot"},  32'($onehot0(bus.bgrant)), 32'd1);
  endtask

  task automatic step(input logic [3:0] req, input string tag);
    @(negedge clk);
    bus.breq = req;
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge(req);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    bus.breq = 4'b0000;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int n0;
    int nt;
    logic [3:0] r;
    logic [3:0] m;

    // Reset with every master requesting: nothing may be granted.
    bus.breq = 4'b1111;
    model_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, "reset");
    check("reset.msel0", 32'(bus.msel), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.breq = 4'b0000;

    // Single requester, hold then drop; msel sticks after release.
    step(4'b0100, "single");
    check("single.grant2", 32'(bus.bgrant), 32'h4);
    check("single.msel2",  32'(bus.msel),   32'd2);
    for (int i = 0; i < 4; i++) step(4'b0100, "single_hold");
    step(4'b0000, "single_drop");
    check("single.dropped", 32'(bus.bgrant), 32'h0);
    check("single.msel_kept", 32'(bus.msel), 32'd2);
    step(4'b0000, "idle");

    // All requesting: rotation 0,1,2,3,0 with a gap cycle between owners.
    do_reset();
    for (int o = 0; o < 5; o++) begin
      m = 4'b0000;
      m[o % 4] = 1'b1;
      step(4'b1111, "rr_grant");
      check("rr.order", 32'(bus.bgrant), 32'(m));
      step(4'b1111, "rr_hold");
      step(4'b1111, "rr_hold");
      step(4'b1111 & ~m, "rr_drop");
      check("rr.gap", 32'(bus.bgrant), 32'h0);
    end

    // Owner release coinciding with a new request: gap first, then grant.
    do_reset();
    step(4'b0001, "sw_grant0");
    step(4'b0001, "sw_hold");
    step(4'b0010, "sw_release");
    check("sw.gap", 32'(bus.bgrant), 32'h0);
    step(4'b0010, "sw_grant1");
    check("sw.grant1", 32'(bus.bgrant), 32'h2);
    check("sw.msel1",  32'(bus.msel),   32'd1);

    // Asynchronous reset in the middle of master 2's grant.
    step(4'b0000, "pre_rst");
    step(4'b0000, "pre_rst");
    step(4'b0100, "mid_grant2");
    check("mid.grant2", 32'(bus.bgrant), 32'h4);
    step(4'b0100, "mid_hold");
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check("async.bgrant", 32'(bus.bgrant), 32'h0);
    check("async.msel",   32'(bus.msel),   32'd0);
    check("async.bbusy",  32'(bus.bbusy),  32'd0);
    step(4'b0101, "rst_hold");
    rstn = 1'b1;
    step(4'b0101, "after_rst");
    check("after_rst.grant0", 32'(bus.bgrant), 32'h1);

    // Two masters requesting constantly: bounded grant only with the timeout build.
    do_reset();
    n0 = 0;
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b0011, "tmo");
      if (bus.bgrant === 4'b0001) n0++;
      if (bus.timeout === 1'b1) nt++;
    end
    if (TMO_EN) begin
      check("tmo.len0",   32'(n0), 32'd8);
      check("tmo.pulses", 32'(nt), 32'd1);
      check("tmo.grant1", 32'(bus.bgrant), 32'h2);
    end else begin
      check("notmo.len0",   32'(n0), 32'd12);
      check("notmo.pulses", 32'(nt), 32'd0);
    end

    // Random traffic; owners mostly keep their request up.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      step(r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
